lpc: RTL and testbench

Passive Low Pin Count (LPC) bus sniffer that decodes host-initiated I/O and memory cycles from the LAD/LFRAME# pins. It never drives the bus. Each completed cycle is published on a capture interface together with a one-cycle strobe. It sits between the LPC pin inputs and the downstream capture/FIFO logic, which samples the outputs on `out_clock_enable`.

---
 rtl/lpc_pkg.sv | 35 +++
 rtl/lpc.sv | 134 +++++++++++++
 tb/tb_lpc.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/lpc_pkg.sv
// Shared types and protocol codes for the passive LPC bus sniffer.
package lpc_pkg;

    typedef enum logic [3:0] {
        IDLE, START, CTDIR, SIZE, ADDR, TAR1, SYNC, DATA, TAR2, DONE
    } state_t;

    localparam logic [1:0] CT_IO  = 2'b00;
    localparam logic [1:0] CT_MEM = 2'b01;

    localparam logic [3:0] START_CODE      = 4'b0000;
    localparam logic [3:0] SYNC_READY      = 4'b0000;
    localparam logic [3:0] SYNC_SHORT_WAIT = 4'b0101;
    localparam logic [3:0] SYNC_LONG_WAIT  = 4'b0110;
    localparam logic [3:0] SYNC_ERROR      = 4'b1010;

    // Zero marks an unsupported size code
    function automatic logic [2:0] size_bytes(input logic [3:0] code);
        case (code)
            4'b0000: return 3'd1;
            4'b0001: return 3'd2;
            4'b0011: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [2:0] data_last(input logic [2:0] bytes);
        case (bytes)
            3'd1:    return 3'd1;
            3'd2:    return 3'd3;
            default: return 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/lpc.sv
// Passive LPC sniffer: decodes host I/O and memory cycles from LAD/LFRAME#
// and publishes each completed cycle with a one-cycle strobe.
module lpc
    import lpc_pkg::*;
(
    input  logic        lpc_clock,
    input  logic        lpc_reset,
    input  logic [3:0]  lpc_ad,
    input  logic        lpc_frame,
    output logic [3:0]  out_cyctype_dir,
    output logic [31:0] out_addr,
    output logic [31:0] out_data,
    output logic [2:0]  out_data_size,
    output logic        out_clock_enable
);

    state_t      state;
    logic [2:0]  cnt;
    logic [2:0]  size;
    logic [3:0]  ctdir;
    logic [3:0]  start_nib;
    logic [31:0] addr_sr;
    logic [31:0] data_sr;

    logic       is_mem;
    logic       is_write;
    logic [2:0] addr_last;

    assign is_mem    = ctdir[3:2] == CT_MEM;
    assign is_write  = ctdir[1];
    assign addr_last = is_mem ? 3'd7 : 3'd3;

    always_ff @(posedge lpc_clock or posedge lpc_reset) begin
        if (lpc_reset) begin
            state            <= IDLE;
            cnt              <= '0;
            size             <= '0;
            ctdir            <= '0;
            start_nib        <= '0;
            addr_sr          <= '0;
            data_sr          <= '0;
            out_cyctype_dir  <= '0;
            out_addr         <= '0;
            out_data         <= '0;
            out_data_size    <= '0;
            out_clock_enable <= 1'b0;
        end else begin
            out_clock_enable <= 1'b0;
            if (state == DONE) begin
                out_cyctype_dir  <= ctdir;
                out_addr         <= addr_sr;
                out_data         <= data_sr;
                out_data_size    <= size;
                out_clock_enable <= 1'b1;
            end
            // Frame low always (re)starts; the last low nibble is kept
            if (!lpc_frame) begin
                state     <= START;
                start_nib <= lpc_ad;
                cnt       <= '0;
                addr_sr   <= '0;
                data_sr   <= '0;
            end else begin
                case (state)
                    START: begin
                        cnt <= '0;
                        if (start_nib != START_CODE) begin
                            state <= IDLE;
                        end else if (lpc_ad[3:2] == CT_IO) begin
                            ctdir <= lpc_ad;
                            size  <= 3'd1;
                            state <= ADDR;
                        end else if (lpc_ad[3:2] == CT_MEM) begin
                            ctdir <= lpc_ad;
                            state <= SIZE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    SIZE: begin
                        if (size_bytes(lpc_ad) == 3'd0) begin
                            state <= IDLE;
                        end else begin
                            size  <= size_bytes(lpc_ad);
                            state <= ADDR;
                        end
                    end
                    ADDR: begin
                        addr_sr <= {addr_sr[27:0], lpc_ad};
                        if (cnt == addr_last) begin
                            cnt   <= '0;
                            state <= is_write ? DATA : TAR1;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                    DATA: begin
                        data_sr[{cnt, 2'b00} +: 4] <= lpc_ad;
                        if (cnt == data_last(size)) begin
                            cnt   <= '0;
                            state <= is_write ? TAR1 : TAR2;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                    TAR1: begin
                        cnt <= cnt + 3'd1;
                        if (cnt == 3'd1) begin
                            cnt   <= '0;
                            state <= SYNC;
                        end
                    end
                    SYNC: begin
                        case (lpc_ad)
                            SYNC_SHORT_WAIT, SYNC_LONG_WAIT: state <= SYNC;
                            SYNC_READY, SYNC_ERROR:
                                state <= is_write ? TAR2 : DATA;
                            default: state <= IDLE;
                        endcase
                    end
                    TAR2: begin
                        cnt <= cnt + 3'd1;
                        if (cnt == 3'd1) begin
                            cnt   <= '0;
                            state <= DONE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lpc.sv
// Randomized self-checking bench for the LPC sniffer against a
// transaction-level model of the host cycles.
module tb_lpc;

    logic        lpc_clock = 1'b0;
    logic        lpc_reset = 1'b1;
    logic [3:0]  lpc_ad = 4'hf;
    logic        lpc_frame = 1'b1;
    logic [3:0]  out_cyctype_dir;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic [2:0]  out_data_size;
    logic        out_clock_enable;

    lpc dut (
        .lpc_clock        (lpc_clock),
        .lpc_reset        (lpc_reset),
        .lpc_ad           (lpc_ad),
        .lpc_frame        (lpc_frame),
        .out_cyctype_dir  (out_cyctype_dir),
        .out_addr         (out_addr),
        .out_data         (out_data),
        .out_data_size    (out_data_size),
        .out_clock_enable (out_clock_enable)
    );

    always #5 lpc_clock = ~lpc_clock;

    int n_checks = 0;
    int n_fail = 0;
    int n_strobe = 0;
    int n_expect = 0;
    logic [70:0] expq[$];
    logic [70:0] hold = '0;
    logic [4:0]  bus[$];

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [70:0] outs();
        return {out_cyctype_dir, out_addr, out_data, out_data_size};
    endfunction

    function automatic int nbytes(input logic [3:0] code);
        case (code)
            4'b0000: return 1;
            4'b0001: return 2;
            4'b0011: return 4;
            default: return 0;
        endcase
    endfunction

    // Expected captures are compared at each strobe; otherwise outputs must hold
    always @(negedge lpc_clock) begin
        if (lpc_reset) begin
            hold = '0;
        end else if (out_clock_enable) begin
            n_strobe++;
            if (expq.size() == 0) begin
                check("unexpected_strobe", 128'(outs()), 128'(hold));
                check("strobe_count", 128'(n_strobe), 128'(n_expect));
            end else begin
                hold = expq.pop_front();
                check("capture", 128'(outs()), 128'(hold));
            end
        end else begin
            check("hold", 128'(outs()), 128'(hold));
        end
    end

    task automatic drive(input logic [4:0] x);
        @(negedge lpc_clock);
        lpc_frame = x[4];
        lpc_ad = x[3:0];
    endtask

    task automatic idle(input int n);
        repeat (n) drive(5'h1f);
    endtask

    // cut: 0 = complete, -1 = random abort, >0 = nibbles kept after START
    task automatic send(input logic [3:0] ct, input logic [3:0] szc,
                        input logic [31:0] addr, input logic [31:0] data,
                        input int waits, input logic [3:0] sync,
                        input int idles, input int cut);
        int pre, nb, n, k;
        bit mem, valid;
        logic [31:0] mask;
        pre = $urandom_range(0, 2);
        mem = ct[3:2] == 2'b01;
        nb = mem ? nbytes(szc) : 1;
        bus.delete();
        repeat (pre) bus.push_back({1'b0, 4'($urandom_range(1, 15))});
        bus.push_back(5'b0_0000);
        bus.push_back({1'b1, ct});
        if (mem) bus.push_back({1'b1, szc});
        for (int i = (mem ? 7 : 3); i >= 0; i--)
            bus.push_back({1'b1, addr[4*i +: 4]});
        if (ct[1]) begin
            for (int j = 0; j < 2 * nb; j++) bus.push_back({1'b1, data[4*j +: 4]});
            repeat (2) bus.push_back(5'h1f);
        end else begin
            repeat (2) bus.push_back(5'h1f);
        end
        repeat (waits)
            bus.push_back({1'b1, ($urandom_range(0, 1) != 0) ? 4'b0101 : 4'b0110});
        bus.push_back({1'b1, sync});
        if (!ct[1])
            for (int j = 0; j < 2 * nb; j++) bus.push_back({1'b1, data[4*j +: 4]});
        repeat (2) bus.push_back(5'h1f);

        valid = (ct[3:2] == 2'b00 || (mem && nb != 0)) &&
                (sync == 4'b0000 || sync == 4'b1010);
        mask = (nb == 1) ? 32'hff : (nb == 2) ? 32'hffff : 32'hffffffff;
        if (cut < 0) cut = $urandom_range(1, bus.size() - pre - 2);
        if (cut == 0 && valid) begin
            n_expect++;
            expq.push_back({ct, mem ? addr : {16'h0, addr[15:0]},
                            data & mask, 3'(nb)});
        end
        n = (cut == 0) ? bus.size() : pre + 1 + cut;
        k = 0;
        foreach (bus[i]) begin
            if (k < n) drive(bus[i]);
            k++;
        end
        idle(idles);
        if (cut == 0 && idles >= 2) begin
            #1;
            check("strobes", 128'(n_strobe), 128'(n_expect));
        end
    endtask

    logic [3:0] cts[9] = '{4'b0000, 4'b0010, 4'b0100, 4'b0110, 4'b0100,
                           4'b0110, 4'b1000, 4'b1100, 4'b0001};
    logic [3:0] szs[5] = '{4'b0000, 4'b0001, 4'b0011, 4'b0011, 4'b0010};

    initial begin
        #1;
        check("reset_state", 128'({out_clock_enable, outs()}), 128'(0));
        repeat (2) @(negedge lpc_clock);
        #2 lpc_reset = 1'b0;
        idle(2);

        send(4'b0110, 4'b0011, 32'h12347fe5, 32'hafd569ce, 0, 4'h0, 2, 0);
        check("memwr32", 128'(outs()),
              128'({4'b0110, 32'h12347fe5, 32'hafd569ce, 3'd4}));

        send(4'b0010, 4'h0, 32'h0000002e, 32'h5a, 0, 4'h0, 2, 0);
        check("iowr8", 128'(outs()),
              128'({4'b0010, 32'h0000002e, 32'h0000005a, 3'd1}));

        send(4'b0100, 4'b0001, 32'hffc00010, 32'hbeef, 3, 4'h0, 2, 0);
        check("memrd16", 128'(outs()),
              128'({4'b0100, 32'hffc00010, 32'h0000beef, 3'd2}));

        send(4'b0010, 4'h0, 32'h00001234, 32'h99, 0, 4'h0, 0, 3);
        send(4'b0000, 4'h0, 32'h00000080, 32'h12, 1, 4'h0, 2, 0);
        check("abort_iord", 128'(outs()),
              128'({4'b0000, 32'h00000080, 32'h00000012, 3'd1}));

        send(4'b1000, 4'h0, 32'h00004444, 32'h77, 0, 4'h0, 2, 0);
        send(4'b0110, 4'b0011, 32'h0badf00d, 32'h11223344, 1, 4'hf, 2, 0);
        check("no_strobe_bad", 128'(outs()),
              128'({4'b0000, 32'h00000080, 32'h00000012, 3'd1}));

        // Reset while the data phase of a memory write is in flight
        send(4'b0110, 4'b0011, 32'hcafe0000, 32'h55667788, 0, 4'h0, 0, 13);
        @(negedge lpc_clock);
        #2 lpc_reset = 1'b1;
        #1;
        check("reset_async", 128'({out_clock_enable, outs()}), 128'(0));
        lpc_frame = 1'b1;
        lpc_ad = 4'hf;
        repeat (2) @(negedge lpc_clock);
        #2 lpc_reset = 1'b0;
        idle(2);
        #1;
        check("reset_nostrobe", 128'(n_strobe), 128'(n_expect));
        send(4'b0010, 4'h0, 32'h00000378, 32'hc3, 0, 4'ha, 2, 0);

        // Back-to-back: next START sampled while the strobe is high
        send(4'b0000, 4'h0, 32'h000003f8, 32'h41, 0, 4'h0, 1, 0);
        send(4'b0100, 4'b0011, 32'hfee00300, 32'h89abcdef, 2, 4'h0, 2, 0);

        for (int t = 0; t < 60; t++) begin
            logic [3:0] ct, szc, sync;
            int r, idles, cut;
            ct = cts[$urandom_range(0, 8)];
            szc = szs[$urandom_range(0, 4)];
            r = $urandom_range(0, 9);
            sync = (r < 6) ? 4'h0 : (r < 9) ? 4'ha : 4'($urandom_range(1, 9));
            cut = ($urandom_range(0, 7) == 0) ? -1 : 0;
            idles = (cut != 0) ? 0 : $urandom_range(1, 3);
            send(ct, szc, $urandom, $urandom, $urandom_range(0, 3), sync,
                 idles, cut);
        end
        send(4'b0010, 4'h0, 32'h00000060, 32'h0f, 0, 4'h0, 3, 0);
        check("queue_empty", 128'(expq.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
